// File: rtl/fetch_stage_if.sv
// fetch_stage_if: fetch-stage handshake bundle (decode control, imem read port, decode-facing outputs)
// Ports (all carried as interface members):
//   stall_i, redirect_i, redirect_pc_i : decode/execute control into the fetch stage
//   imem_addr_o, imem_data_i           : instruction memory read port (one-cycle read latency)
//   if_pc_o, if_instr_o, if_valid_o    : instruction delivered to decode
//   fetch_misalign_o                   : sticky misaligned-redirect fault
// master = fetch stage, slave = surrounding pipeline/memory.
interface fetch_stage_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  stall_i;
    logic                  redirect_i;
    logic [31:0]           redirect_pc_i;
    logic [ADDR_WIDTH-1:0] imem_addr_o;
    logic [31:0]           imem_data_i;
    logic [31:0]           if_pc_o;
    logic [31:0]           if_instr_o;
    logic                  if_valid_o;
    logic                  fetch_misalign_o;
    modport master (
        input  stall_i, redirect_i, redirect_pc_i, imem_data_i,
        output imem_addr_o, if_pc_o, if_instr_o, if_valid_o, fetch_misalign_o
    );
    modport slave (
        output stall_i, redirect_i, redirect_pc_i, imem_data_i,
        input  imem_addr_o, if_pc_o, if_instr_o, if_valid_o, fetch_misalign_o
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: program counter + instruction fetch with stall skid register and redirect bubble
// Ports:
//   clk          : clock, all state on rising edge
//   rst          : asynchronous active-high reset
//   bus (master) : fetch_stage_if bundle, see rtl/fetch_stage_if.sv
// Parameters: RESET_PC (first fetched byte address), ADDR_WIDTH (imem byte-address width).
// Option macro FETCH_MISALIGN_TRAP_EN: when defined, a misaligned redirect raises a sticky
// fault and halts fetch until an aligned redirect; when undefined, targets are word-aligned.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 14
) (
    input logic       clk,
    input logic       rst,
    fetch_stage_if.master bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic        hold_valid_q, hold_valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] target;
    logic        halted;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign target     = bus.redirect_pc_i;
    assign misalign_d = bus.redirect_i ? |bus.redirect_pc_i[1:0] : misalign_q;
    assign halted     = misalign_q;
`else
    assign target     = bus.redirect_pc_i & ~32'h3;
    assign misalign_d = 1'b0;
    assign halted     = 1'b0;
`endif
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        resp_pc_d    = resp_pc_q;
        resp_valid_d = resp_valid_q;
        hold_instr_d = hold_instr_q;
        hold_valid_d = hold_valid_q;
        if (bus.redirect_i) begin
            fetch_pc_d   = target;
            resp_valid_d = 1'b0;
            hold_valid_d = 1'b0;
        end else if (bus.stall_i) begin
            // Capture the word now on imem_data_i before the already-advanced
            // fetch_pc's data overwrites it on the next edge.
            if (resp_valid_q && !hold_valid_q) begin
                hold_instr_d = bus.imem_data_i;
                hold_valid_d = 1'b1;
            end
        end else if (!halted) begin
            resp_pc_d    = fetch_pc_q;
            resp_valid_d = 1'b1;
            fetch_pc_d   = fetch_pc_q + 32'd4;
            hold_valid_d = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q   <= RESET_PC;
            resp_pc_q    <= RESET_PC;
            resp_valid_q <= 1'b0;
            hold_instr_q <= 32'h0;
            hold_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            resp_pc_q    <= resp_pc_d;
            resp_valid_q <= resp_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_valid_q <= hold_valid_d;
            misalign_q   <= misalign_d;
        end
    end
    assign bus.imem_addr_o      = fetch_pc_q[ADDR_WIDTH-1:0];
    assign bus.if_pc_o          = resp_pc_q;
    assign bus.if_valid_o       = resp_valid_q;
    assign bus.if_instr_o       = !resp_valid_q ? NOP : hold_valid_q ? hold_instr_q : bus.imem_data_i;
    assign bus.fetch_misalign_o = misalign_q;
endmodule
